// File: rtl/prog_timer.sv
// prog_timer: prescaled programmable timer with a runtime-loadable terminal count, periodic or one-shot
// operation and a registered one-cycle elapsed pulse. Define PROG_TIMER_STICKY_FLAG_EN for elapsed_flag/flag_ack.
module prog_timer #(
  parameter int                WIDTH          = 32,
  parameter int                PRESCALE_WIDTH = 8,
  parameter longint unsigned   DEFAULT_PERIOD = 49_999_999
) (
  input  logic                      clk,
  input  logic                      async_reset,
  input  logic                      enable,
  input  logic                      clear,
  input  logic                      load,
  input  logic [WIDTH-1:0]          period_in,
  input  logic [PRESCALE_WIDTH-1:0] prescale_in,
  input  logic                      one_shot,
  output logic [WIDTH-1:0]          count_out,
  output logic                      elapsed,
`ifdef PROG_TIMER_STICKY_FLAG_EN
  input  logic                      flag_ack,
  output logic                      elapsed_flag,
`endif
  output logic                      running
);

  localparam logic [WIDTH-1:0] RESET_PERIOD = WIDTH'(DEFAULT_PERIOD);

  logic [WIDTH-1:0]          count;
  logic [WIDTH-1:0]          period;
  logic [PRESCALE_WIDTH-1:0] pre_cnt;
  logic [PRESCALE_WIDTH-1:0] prescale;
  logic                      done;

  logic active_p0;
  logic tick_p0;
  logic terminal_p0;
  logic restart_p0;

  function automatic logic [PRESCALE_WIDTH-1:0] pre_next(
    input logic [PRESCALE_WIDTH-1:0] cur,
    input logic [PRESCALE_WIDTH-1:0] lim
  );
    return (cur == lim) ? '0 : cur + PRESCALE_WIDTH'(1);
  endfunction

  // Terminal uses >= so a count left above a lowered period still terminates on the next tick.
  function automatic logic [WIDTH-1:0] count_next(
    input logic [WIDTH-1:0] cur,
    input logic             terminal
  );
    return terminal ? '0 : cur + WIDTH'(1);
  endfunction

  // ---- stage p0: tick / terminal decode from current state ----
  assign active_p0   = enable & ~done;
  assign tick_p0     = active_p0 & (pre_cnt == prescale);
  assign terminal_p0 = tick_p0 & (count >= period);
  assign restart_p0  = load | clear;

  assign count_out = count;
  assign running   = active_p0;

  // ---- stage p1: registered state ----
  always_ff @(posedge clk or posedge async_reset) begin
    if (async_reset) begin
      period   <= RESET_PERIOD;
      prescale <= '0;
    end else if (load) begin
      period   <= period_in;
      prescale <= prescale_in;
    end
  end

  always_ff @(posedge clk or posedge async_reset) begin
    if (async_reset) begin
      count   <= '0;
      pre_cnt <= '0;
    end else if (restart_p0) begin
      count   <= '0;
      pre_cnt <= '0;
    end else if (active_p0) begin
      pre_cnt <= pre_next(pre_cnt, prescale);
      if (tick_p0) begin
        count <= count_next(count, terminal_p0);
      end
    end
  end

  // A terminal tick coinciding with clear/load is dropped: restart wins outright.
  always_ff @(posedge clk or posedge async_reset) begin
    if (async_reset) begin
      done    <= 1'b0;
      elapsed <= 1'b0;
    end else if (restart_p0) begin
      done    <= 1'b0;
      elapsed <= 1'b0;
    end else begin
      elapsed <= terminal_p0;
      if (terminal_p0 && one_shot) begin
        done <= 1'b1;
      end
    end
  end

`ifdef PROG_TIMER_STICKY_FLAG_EN
  // Set wins over a simultaneous acknowledge.
  always_ff @(posedge clk or posedge async_reset) begin
    if (async_reset) begin
      elapsed_flag <= 1'b0;
    end else if (restart_p0) begin
      elapsed_flag <= 1'b0;
    end else if (terminal_p0) begin
      elapsed_flag <= 1'b1;
    end else if (flag_ack) begin
      elapsed_flag <= 1'b0;
    end
  end
`endif

endmodule
